muldiv_seq: RTL and testbench

Multi-cycle sequencer for the MUL and DIV operations selected by the 4-bit ALU control code. The single-cycle ALU path cannot complete these operations in one cycle. The block takes the ALU control code and two operands, then runs an iterative shift-add multiply or a restoring divide, one bit per clock. It reports busy/done so the core controller can stall the PC and register write-back until the result is ready.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 49 ++++
 rtl/muldiv_seq.sv | 127 ++++++++++++
 tb/tb_muldiv_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU control codes and the muldiv_seq state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b0110;
    localparam logic [3:0] ALU_NOP  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTI = 4'b1011;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MUL_RUN = 2'd1;
    localparam logic [1:0] ST_DIV_RUN = 2'd2;
    localparam logic [1:0] ST_FINISH  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of shift-add multiply or
//               restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_is_div,
    input  logic [2*WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0]   i_q,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH:0]   o_acc,
    output logic [WIDTH-1:0]   o_q
);

    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH:0] w_mul_acc;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_q_sh;

    always_comb begin
        // Multiply: the upper-half add keeps its carry in the extra top bit.
        w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
        w_mul_acc = i_q[0] ? {w_sum, i_acc[WIDTH-1:0]} : i_acc;

        // Divide: remainder lives in the low WIDTH+1 bits of the accumulator.
        w_rem_sh  = {i_acc[WIDTH-1:0], i_q[WIDTH-1]};
        w_q_sh    = {i_q[WIDTH-2:0], 1'b0};
        w_ge      = (w_rem_sh >= {1'b0, i_operand});
        w_sub     = w_rem_sh - {1'b0, i_operand};

        if (i_is_div) begin
            o_acc = {{WIDTH{1'b0}}, (w_ge ? w_sub : w_rem_sh)};
            o_q   = w_q_sh | {{(WIDTH-1){1'b0}}, w_ge};
        end else begin
            o_acc = w_mul_acc >> 1;
            o_q   = i_q >> 1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module      : muldiv_seq
// Description : Multi-cycle MUL/DIV sequencer, one bit per clock with
//               busy/done handshake for the core controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] C_ITER = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2*WIDTH:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_result_lo;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_dbz;

    logic [2*WIDTH:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_is_div;

    assign w_is_div = (r_state == ST_DIV_RUN);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div  (w_is_div),
        .i_acc     (r_acc),
        .i_q       (r_q),
        .i_operand (r_operand),
        .o_acc     (w_acc_nxt),
        .o_q       (w_q_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_operand   <= '0;
            r_result_lo <= '0;
            r_result_hi <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && alu_ctrl == ALU_MUL) begin
                        r_operand <= op_a;
                        r_q       <= op_b;
                        r_acc     <= '0;
                        r_cnt     <= C_ITER;
                        r_dbz     <= 1'b0;
                        r_state   <= ST_MUL_RUN;
                    end else if (start && alu_ctrl == ALU_DIV) begin
                        if (op_b == '0) begin
                            r_result_lo <= '1;
                            r_result_hi <= op_a;
                            r_dbz       <= 1'b1;
                            r_state     <= ST_FINISH;
                        end else begin
                            r_operand <= op_b;
                            r_q       <= op_a;
                            r_acc     <= '0;
                            r_cnt     <= C_ITER;
                            r_dbz     <= 1'b0;
                            r_state   <= ST_DIV_RUN;
                        end
                    end
                end
                ST_MUL_RUN, ST_DIV_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt - C_ONE;
                    if (r_cnt == C_ONE) begin
                        // Results are captured on the final iteration so they are valid with done.
                        if (w_is_div) begin
                            r_result_lo <= w_q_nxt;
                            r_result_hi <= w_acc_nxt[WIDTH-1:0];
                        end else begin
                            r_result_lo <= w_acc_nxt[WIDTH-1:0];
                            r_result_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
                        end
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state == ST_MUL_RUN) || (r_state == ST_DIV_RUN);
    assign done        = (r_state == ST_FINISH);
    assign result_lo   = r_result_lo;
    assign result_hi   = r_result_hi;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Scoreboard bench for muldiv_seq: expected results queued at
//               issue, popped and compared when done appears.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_seq;

    localparam logic [3:0] C_MUL = 4'b0010;
    localparam logic [3:0] C_DIV = 4'b0011;
    localparam logic [3:0] C_ADD = 4'b0000;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        div_by_zero;

    res_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   n_done;

    muldiv_seq #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_ctrl    (alu_ctrl),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) n_done <= n_done + 1;
    end

    // Reference: full-width product, native divide, and the divide-by-zero convention.
    function automatic res_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        logic [63:0] p;
        r = '0;
        if (c == C_MUL) begin
            p    = {32'b0, a} * {32'b0, b};
            r.lo = p[31:0];
            r.hi = p[63:32];
        end else if (b == 32'd0) begin
            r.lo  = 32'hFFFF_FFFF;
            r.hi  = a;
            r.dbz = 1'b1;
        end else begin
            r.lo = a / b;
            r.hi = a % b;
        end
        return r;
    endfunction

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start    = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        alu_ctrl = 4'b0111;
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    // Waits (bounded) for done; lat = 0 means the bound expired.
    task automatic wait_done(output int lat, output int busy_cyc, output res_t obs);
        lat      = 0;
        busy_cyc = 0;
        obs      = '0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                obs = {result_lo, result_hi, div_by_zero};
                break;
            end
            if (busy === 1'b1) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({busy, done, result_lo, result_hi, div_by_zero} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b done=%b lo=%h hi=%h dbz=%b, expected all zero",
                     busy, done, result_lo, result_hi, div_by_zero);
        end
    endtask

    task automatic run_and_check(input string name, input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input int exp_lat, input int exp_busy);
        int   lat;
        int   bc;
        res_t obs;
        res_t e;
        exp_q.push_back(model(c, a, b));
        issue(c, a, b);
        wait_done(lat, bc, obs);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (bc !== exp_busy) begin
            n_bad++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bc, exp_busy);
        end
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL %s_result: got lo=%h hi=%h dbz=%b expected lo=%h hi=%h dbz=%b",
                     name, obs.lo, obs.hi, obs.dbz, e.lo, e.hi, e.dbz);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done_pulse: got done=%b expected 0", name, done);
        end
    endtask

    task automatic test_mul();
        run_and_check("mul_7x6", C_MUL, 32'd7, 32'd6, 33, 32);
        n_cmp++;
        if ({result_hi, result_lo} !== 64'h0000_0000_0000_002A) begin
            n_bad++;
            $display("FAIL mul_7x6_hold: got %h_%h expected 00000000_0000002a", result_hi, result_lo);
        end
        run_and_check("mul_max", C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32);
        n_cmp++;
        if ({result_hi, result_lo, div_by_zero} !== {64'hFFFF_FFFE_0000_0001, 1'b0}) begin
            n_bad++;
            $display("FAIL mul_max_const: got hi=%h lo=%h dbz=%b expected fffffffe 00000001 0",
                     result_hi, result_lo, div_by_zero);
        end
        for (int i = 0; i < 3; i++) run_and_check("mul_rand", C_MUL, $urandom, $urandom, 33, 32);
    endtask

    task automatic test_div();
        run_and_check("div_100_7", C_DIV, 32'd100, 32'd7, 33, 32);
        n_cmp++;
        if ({result_lo, result_hi} !== {32'd14, 32'd2}) begin
            n_bad++;
            $display("FAIL div_100_7_const: got q=%0d r=%0d expected q=14 r=2", result_lo, result_hi);
        end
        run_and_check("div_msb_1", C_DIV, 32'h8000_0000, 32'd1, 33, 32);
        run_and_check("div_small_big", C_DIV, 32'd3, 32'hFFFF_FFF0, 33, 32);
        for (int i = 0; i < 3; i++) run_and_check("div_rand", C_DIV, $urandom, $urandom_range(1, 65535), 33, 32);
    endtask

    task automatic test_div_zero();
        int   lat;
        int   bc;
        res_t obs;
        res_t e;
        run_and_check("div_5_0", C_DIV, 32'd5, 32'd0, 1, 0);
        exp_q.push_back(model(C_MUL, 32'd11, 32'd13));
        issue(C_MUL, 32'd11, 32'd13);
        @(negedge clk);
        n_cmp++;
        if (div_by_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL dbz_clear: got %b expected 0", div_by_zero);
        end
        wait_done(lat, bc, obs);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL dbz_then_mul: got lo=%h hi=%h dbz=%b expected lo=%h hi=%h dbz=%b",
                     obs.lo, obs.hi, obs.dbz, e.lo, e.hi, e.dbz);
        end
    endtask

    task automatic test_ignore();
        int   lat;
        int   bc;
        int   d0;
        res_t obs;
        res_t e;
        logic [31:0] prev_lo;
        prev_lo = 32'd143;
        issue(C_ADD, 32'd1, 32'd2);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, result_lo} !== {1'b0, 1'b0, prev_lo}) begin
            n_bad++;
            $display("FAIL ignore_add: got busy=%b done=%b lo=%h expected 0 0 %h", busy, done, result_lo, prev_lo);
        end
        d0 = n_done;
        exp_q.push_back(model(C_MUL, 32'h1234_5678, 32'h0000_9ABC));
        issue(C_MUL, 32'h1234_5678, 32'h0000_9ABC);
        repeat (8) @(negedge clk);
        issue(C_MUL, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        wait_done(lat, bc, obs);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL ignore_busy_result: got lo=%h hi=%h expected lo=%h hi=%h", obs.lo, obs.hi, e.lo, e.hi);
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if (n_done - d0 !== 1) begin
            n_bad++;
            $display("FAIL ignore_done_count: got %0d expected 1", n_done - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        exp_q.push_back(model(C_DIV, 32'd1000, 32'd3));
        issue(C_DIV, 32'd1000, 32'd3);
        repeat (13) @(negedge clk);
        d0 = n_done;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_cmp++;
        if ({busy, done, result_lo, result_hi, div_by_zero} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_mid_state: got busy=%b done=%b lo=%h hi=%h dbz=%b, expected all zero",
                     busy, done, result_lo, result_hi, div_by_zero);
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if (n_done !== d0) begin
            n_bad++;
            $display("FAIL reset_mid_no_done: got %0d dones expected 0", n_done - d0);
        end
        run_and_check("mul_3x3", C_MUL, 32'd3, 32'd3, 33, 32);
        n_cmp++;
        if (result_lo !== 32'd9) begin
            n_bad++;
            $display("FAIL mul_3x3_const: got %0d expected 9", result_lo);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        n_done   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        alu_ctrl = 4'b0000;
        op_a     = '0;
        op_b     = '0;
        repeat (3) @(posedge clk);
        test_reset();
        #1 rst_n = 1'b1;
        test_mul();
        test_div();
        test_div_zero();
        test_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
